// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared widths and constants for the writeback arbiter slice.
//               DATA_W    - register data width
//               ADDR_W    - register address width (2**ADDR_W registers)
//               LDQ_DEPTH - maximum outstanding loads (power of two)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int LDQ_DEPTH = 4;
  localparam int NUM_REGS  = 1 << ADDR_W;
  localparam int CNT_W     = $clog2(LDQ_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of the execute/memory side handshakes, the register
//               file write port and the scoreboard/status outputs.
//               slave  - view taken by wb_arbiter
//               master - view taken by the pipeline driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                ld_issue;
  logic                ld_issue_ready;
  logic [ADDR_W-1:0]   ld_rd;
  logic                ld_resp_valid;
  logic [DATA_W-1:0]   ld_resp_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    pending_cnt;
  logic                err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
    output alu_ready, ld_issue_ready,
    output wr_en, wr_addr, wr_data,
    output busy, pending_cnt, err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
    input  alu_ready, ld_issue_ready,
    input  wr_en, wr_addr, wr_data,
    input  busy, pending_cnt, err
  );

endinterface

`default_nettype wire

// File: rtl/wb_arbiter_ld_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ld_tag_fifo
// Description : Synchronous FIFO of load destination tags. Exposes every
//               storage slot plus a per-slot valid mask so the parent can
//               OR-reduce the outstanding destinations.
//   clk, rstd          - clock, asynchronous active-low reset
//   push, din          - enqueue (ignored while full, even if popping)
//   pop, dout          - dequeue (ignored while empty), dout is the head
//   full, empty, count - occupancy status
//   entries, valid     - raw slot contents and which slots are occupied
// Revision    : 1.0 - initial release
// ============================================================================
module ld_tag_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstd,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            wr_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the head (modulo DEPTH, which
  // the power-of-two pointer width gives for free) is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset   = PTR_W'(i) - rd_ptr;
    assign valid[i] = ({1'b0, offset} < count);
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Owns the register file write port. Merges ALU results and
//               in-order load returns into one registered write per cycle
//               (load > skid-buffered ALU > new ALU) and publishes a busy
//               scoreboard of pending load destinations.
//   clk  - clock
//   rstd - asynchronous active-low reset
//   bus  - wb_arbiter_if.slave: ALU/load handshakes, wr_en/wr_addr/wr_data,
//          busy, pending_cnt, sticky err
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rstd,
  wb_arbiter_if.slave  bus
);

  logic                            fifo_full;
  logic                            fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  logic [ADDR_W-1:0]               fifo_head;
  logic [LDQ_DEPTH-1:0][ADDR_W-1:0] fifo_entries;
  logic [LDQ_DEPTH-1:0]            fifo_valid;

  logic                skid_full;
  logic [ADDR_W-1:0]   skid_rd;
  logic [DATA_W-1:0]   skid_data;
  logic                skid_full_nxt;
  logic [ADDR_W-1:0]   skid_rd_nxt;
  logic [DATA_W-1:0]   skid_data_nxt;

  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;

  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                err_q;
  logic                err_set;
  logic [NUM_REGS-1:0] busy_vec;

  logic alu_accept;
  logic ld_write;

  ld_tag_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (LDQ_DEPTH)
  ) u_ld_tag_fifo (
    .clk     (clk),
    .rstd    (rstd),
    .push    (bus.ld_issue),
    .din     (bus.ld_rd),
    .pop     (bus.ld_resp_valid),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .entries (fifo_entries),
    .valid   (fifo_valid)
  );

  // alu_ready depends only on the skid register, so a load response can
  // never combinationally stall the ALU handshake. While the skid holds an
  // entry nothing new is accepted, so the skid never needs to hold two.
  assign alu_accept = bus.alu_valid & ~skid_full;
  assign ld_write   = bus.ld_resp_valid & ~fifo_empty;
  assign err_set    = (bus.ld_issue & fifo_full) | (bus.ld_resp_valid & fifo_empty);

  always_comb begin
    sel_valid     = 1'b0;
    sel_rd        = bus.alu_rd;
    sel_data      = bus.alu_data;
    skid_full_nxt = skid_full;
    skid_rd_nxt   = skid_rd;
    skid_data_nxt = skid_data;
    if (ld_write) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_head;
      sel_data  = bus.ld_resp_data;
      if (alu_accept) begin
        skid_full_nxt = 1'b1;
        skid_rd_nxt   = bus.alu_rd;
        skid_data_nxt = bus.alu_data;
      end
    end else if (skid_full) begin
      sel_valid     = 1'b1;
      sel_rd        = skid_rd;
      sel_data      = skid_data;
      skid_full_nxt = 1'b0;
    end else if (alu_accept) begin
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      skid_full <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
      skid_rd   <= skid_rd_nxt;
      skid_data <= skid_data_nxt;
      // r0 writes are consumed like any other but never reach the file.
      wr_en_q   <= sel_valid && (sel_rd != ZERO_REG);
      if (sel_valid) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_entries[i] != ZERO_REG)) begin
        busy_vec[fifo_entries[i]] = 1'b1;
      end
    end
  end

  assign bus.alu_ready      = ~skid_full;
  assign bus.ld_issue_ready = ~fifo_full;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.busy           = busy_vec;
  assign bus.pending_cnt    = fifo_count;
  assign bus.err            = err_q;

endmodule

`default_nettype wire
